regfile_multiport: RTL and testbench

Parametrised successor to the single-write 32x32 register file.
- Two combinational read ports and two clocked write ports, with fixed priority when both write ports target the same register.
- Per-register valid bits, so reads of never-written registers are flagged explicitly rather than returning X.
- Optional same-cycle write-to-read bypass.
- A sequential clear sweep. Serves as the CPU datapath register file.

---
 rtl/regfile_multiport.sv | 122 ++++++++++++
 tb/tb_regfile_multiport.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multiport register file: two combinational read ports, two clocked write
// ports (B wins on collision), per-register valid bits, optional bypass, clear sweep.
module regfile_multiport #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    output logic                 ReadValid1,
    output logic                 ReadValid2,
    input  logic [ADDR_BITS-1:0] WriteRegisterA,
    input  logic [WIDTH-1:0]     WriteDataA,
    input  logic                 RegWriteA,
    input  logic [ADDR_BITS-1:0] WriteRegisterB,
    input  logic [WIDTH-1:0]     WriteDataB,
    input  logic                 RegWriteB,
    input  logic                 ClearReq,
    output logic                 Busy
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic                 busy;

    function automatic logic is_zero(input logic [ADDR_BITS-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Stored contents, with a pending write forwarded when bypass is enabled.
    function automatic logic [WIDTH:0] read_port(input logic [ADDR_BITS-1:0] ra);
        logic [WIDTH:0] r;
        r = {valid_q[ra], regs_q[ra]};
        if (is_zero(ra)) begin
            r = {1'b1, {WIDTH{1'b0}}};
        end else if (BYPASS != 0 && !busy) begin
            if (RegWriteA && WriteRegisterA == ra) r = {1'b1, WriteDataA};
            if (RegWriteB && WriteRegisterB == ra) r = {1'b1, WriteDataB};
        end
        return r;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ClearReq) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    assign Busy = busy;

    // The sweep owns the array while busy; otherwise B is applied after A so it wins.
    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        if (busy) begin
            regs_d[cnt_q]  = '0;
            valid_d[cnt_q] = 1'b0;
        end else begin
            if (RegWriteA && !is_zero(WriteRegisterA)) begin
                regs_d[WriteRegisterA]  = WriteDataA;
                valid_d[WriteRegisterA] = 1'b1;
            end
            if (RegWriteB && !is_zero(WriteRegisterB)) begin
                regs_d[WriteRegisterB]  = WriteDataB;
                valid_d[WriteRegisterB] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            valid_q <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        {ReadValid1, ReadData1} = read_port(ReadRegister1);
        {ReadValid2, ReadData2} = read_port(ReadRegister2);
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with a scoreboard queue of expected results.
module tb_regfile_multiport;
    logic        Clk, Reset_n;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegisterA, WriteRegisterB;
    logic [31:0] WriteDataA, WriteDataB;
    logic        RegWriteA, RegWriteB, ClearReq;
    logic [31:0] ReadData1, ReadData2, nb_ReadData1, nb_ReadData2;
    logic        ReadValid1, ReadValid2, nb_ReadValid1, nb_ReadValid2;
    logic        Busy, nb_Busy;

    int vectors = 0;
    int miscompares = 0;
    int busy_cnt;

    typedef struct {
        string       tag;
        logic [32:0] exp;
    } sb_t;
    sb_t sbq[$];

    regfile_multiport #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ReadValid1(ReadValid1), .ReadValid2(ReadValid2),
        .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA), .RegWriteA(RegWriteA),
        .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB), .RegWriteB(RegWriteB),
        .ClearReq(ClearReq), .Busy(Busy)
    );

    regfile_multiport #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(nb_ReadData1), .ReadData2(nb_ReadData2),
        .ReadValid1(nb_ReadValid1), .ReadValid2(nb_ReadValid2),
        .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA), .RegWriteA(RegWriteA),
        .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB), .RegWriteB(RegWriteB),
        .ClearReq(ClearReq), .Busy(nb_Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [32:0] rd1();
        return {ReadValid1, ReadData1};
    endfunction

    function automatic logic [32:0] rd2();
        return {ReadValid2, ReadData2};
    endfunction

    function automatic logic [32:0] busy_v();
        return {32'd0, Busy};
    endfunction

    task automatic sb_push(input string tag, input logic [32:0] e);
        sb_t item;
        item.tag = tag;
        item.exp = e;
        sbq.push_back(item);
    endtask

    task automatic sb_check(input logic [32:0] obs);
        sb_t item;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h with no expected entry", obs);
        end else begin
            item = sbq.pop_front();
            assert (obs === item.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
            end
        end
    endtask

    // Advance past the next rising edge; inputs change 2 time units after it.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle_writes();
        RegWriteA = 1'b0;
        RegWriteB = 1'b0;
        ClearReq  = 1'b0;
    endtask

    initial begin
        Clk = 1'b0;
        Reset_n = 1'b0;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd3;
        WriteRegisterA = '0; WriteDataA = '0; RegWriteA = 1'b0;
        WriteRegisterB = '0; WriteDataB = '0; RegWriteB = 1'b0;
        ClearReq = 1'b0;
        #2;

        // Reset state
        sb_push("rst_busy", 33'd0);             sb_check(busy_v());
        sb_push("rst_r5", {1'b0, 32'd0});       sb_check(rd1());
        sb_push("rst_r3", {1'b0, 32'd0});       sb_check(rd2());
        ReadRegister1 = 5'd0; #1;
        sb_push("rst_r0", {1'b1, 32'd0});       sb_check(rd1());
        cyc();
        Reset_n = 1'b1;
        cyc();

        // Single writes through port A, read back on both ports
        WriteRegisterA = 5'd2; WriteDataA = 32'd42; RegWriteA = 1'b1;
        ReadRegister1 = 5'd2; ReadRegister2 = 5'd2;
        sb_push("w42_p1", {1'b1, 32'd42});
        sb_push("w42_p2", {1'b1, 32'd42});
        cyc(); idle_writes(); #1;
        sb_check(rd1()); sb_check(rd2());
        WriteDataA = 32'd15; RegWriteA = 1'b1;
        sb_push("w15_p1", {1'b1, 32'd15});
        sb_push("w15_p2", {1'b1, 32'd15});
        cyc(); idle_writes(); #1;
        sb_check(rd1()); sb_check(rd2());

        // Collision: B wins, both in bypass and in storage
        WriteRegisterA = 5'd4; WriteDataA = 32'd7;  RegWriteA = 1'b1;
        WriteRegisterB = 5'd4; WriteDataB = 32'd9;  RegWriteB = 1'b1;
        ReadRegister1 = 5'd4; #1;
        sb_push("coll_byp", {1'b1, 32'd9});     sb_check(rd1());
        cyc();
        WriteRegisterA = 5'd6; WriteDataA = 32'd11;
        WriteRegisterB = 5'd7; WriteDataB = 32'd13;
        cyc(); idle_writes();
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd6; #1;
        sb_push("coll_r4", {1'b1, 32'd9});      sb_check(rd1());
        sb_push("dual_r6", {1'b1, 32'd11});     sb_check(rd2());
        ReadRegister1 = 5'd7; #1;
        sb_push("dual_r7", {1'b1, 32'd13});     sb_check(rd1());

        // Register 0 ignores writes; disabled write leaves state untouched
        WriteRegisterA = 5'd0; WriteDataA = 32'd25; RegWriteA = 1'b1;
        ReadRegister1 = 5'd0; #1;
        sb_push("r0_byp", {1'b1, 32'd0});       sb_check(rd1());
        cyc(); idle_writes(); #1;
        sb_push("r0_after", {1'b1, 32'd0});     sb_check(rd1());
        WriteRegisterA = 5'd5; WriteDataA = 32'd15; RegWriteA = 1'b0;
        ReadRegister2 = 5'd5;
        cyc(); #1;
        sb_push("noen_r5", {1'b0, 32'd0});      sb_check(rd2());

        // Bypass vs. no-bypass build
        WriteRegisterA = 5'd8; WriteDataA = 32'hDEADBEEF; RegWriteA = 1'b1;
        ReadRegister1 = 5'd8; #1;
        sb_push("byp_pre", {1'b1, 32'hDEADBEEF});  sb_check(rd1());
        sb_push("nobyp_pre", {1'b0, 32'd0});       sb_check({nb_ReadValid1, nb_ReadData1});
        cyc(); idle_writes(); #1;
        sb_push("byp_post", {1'b1, 32'hDEADBEEF}); sb_check(rd1());
        sb_push("nobyp_post", {1'b1, 32'hDEADBEEF}); sb_check({nb_ReadValid1, nb_ReadData1});

        // Clear sweep: write on the entry edge still commits, then everything is wiped
        WriteRegisterA = 5'd1; WriteDataA = 32'h11; RegWriteA = 1'b1;
        WriteRegisterB = 5'd2; WriteDataB = 32'h22; RegWriteB = 1'b1;
        cyc(); RegWriteB = 1'b0;
        WriteRegisterA = 5'd3; WriteDataA = 32'h33;
        cyc();
        WriteRegisterA = 5'd5; WriteDataA = 32'h55; RegWriteA = 1'b1;
        ClearReq = 1'b1;
        cyc(); idle_writes();
        ReadRegister2 = 5'd5; #1;
        sb_push("entry_wr", {1'b1, 32'h55});    sb_check(rd2());
        busy_cnt = 0;
        for (int k = 1; k <= 100 && Busy; k++) begin
            busy_cnt++;
            if (k == 5) ClearReq = 1'b1;
            if (k == 10) begin
                WriteRegisterA = 5'd1; WriteDataA = 32'h99; RegWriteA = 1'b1;
                ReadRegister1 = 5'd1; #1;
                sb_push("clr_nobyp", {1'b0, 32'd0}); sb_check(rd1());
            end
            if (k == 32) begin
                WriteRegisterB = 5'd30; WriteDataB = 32'h77; RegWriteB = 1'b1;
            end
            cyc(); idle_writes(); #1;
        end
        sb_push("busy_len", 33'd32);            sb_check(33'(busy_cnt));
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i); #1;
            sb_push("swept_p1", {(i == 0), 32'd0});  sb_check(rd1());
            sb_push("swept_p2", {(i == 31), 32'd0}); sb_check(rd2());
        end

        // Reset in the middle of a sweep
        WriteRegisterA = 5'd20; WriteDataA = 32'h2020; RegWriteA = 1'b1;
        WriteRegisterB = 5'd21; WriteDataB = 32'h2121; RegWriteB = 1'b1;
        cyc(); idle_writes();
        ClearReq = 1'b1;
        cyc(); ClearReq = 1'b0;
        for (int k = 1; k < 12; k++) cyc();
        #1;
        sb_push("mid_busy", 33'd1);             sb_check(busy_v());
        Reset_n = 1'b0; #1;
        sb_push("abort_busy", 33'd0);           sb_check(busy_v());
        ReadRegister1 = 5'd20; ReadRegister2 = 5'd21; #1;
        sb_push("abort_r20", {1'b0, 32'd0});    sb_check(rd1());
        sb_push("abort_r21", {1'b0, 32'd0});    sb_check(rd2());
        cyc();
        Reset_n = 1'b1;
        cyc(); #1;
        sb_push("post_busy", 33'd0);            sb_check(busy_v());
        WriteRegisterA = 5'd9; WriteDataA = 32'hAB; RegWriteA = 1'b1;
        ReadRegister1 = 5'd9;
        cyc(); idle_writes(); #1;
        sb_push("post_wr", {1'b1, 32'hAB});     sb_check(rd1());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
